// File: rtl/matmul_pkg.sv
// Shared types and constants for the matrix-multiplier stream feeder.
package matmul_pkg;

  localparam int N       = 8;
  localparam int W_BEATS = 64;
  localparam int X_BEATS = 8;
  localparam int X_BASE  = 64;
  localparam int SRC_AW  = 8;
  localparam int DST_AW  = 7;
  localparam int VEC_W   = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEND_W = 3'd1,
    SEND_X = 3'd2,
    RECV_Y = 3'd3,
    DONE   = 3'd4
  } feeder_state_t;

  // One past the last operand address the fetcher may read while serving vector vec.
  function automatic logic [SRC_AW-1:0] x_end_addr(input logic [VEC_W-1:0] vec);
    return SRC_AW'(X_BASE) + {1'b0, vec, 3'b000} + SRC_AW'(X_BEATS);
  endfunction

endpackage

// File: rtl/matmul_beat_fifo2.sv
// Two-entry FIFO holding operand bytes between the operand RAM and the beat port.
module matmul_beat_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/matmul_stream_feeder.sv
// Feeds W/X operand beats from the operand RAM into the matrix multiplier and
// writes the returned results into the result RAM, one command at a time.
module matmul_stream_feeder #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 19,
  parameter int N      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_start,
  output logic              cmd_ready,
  input  logic              cmd_load_w,
  input  logic [3:0]        cmd_nvec,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              src_rd_en,
  output logic [7:0]        src_addr,
  input  logic [DATA_W-1:0] src_data,
  output logic [DATA_W-1:0] data_to_mm,
  output logic              input_valid,
  input  logic              input_ready,
  output logic              new_matrix,
  input  logic              output_valid,
  output logic              output_ready,
  input  logic [ACC_W-1:0]  result,
  output logic              dst_wr_en,
  output logic [6:0]        dst_addr,
  output logic [ACC_W-1:0]  dst_data
);
  import matmul_pkg::*;

  localparam logic [5:0] W_LAST = 6'(N * N - 1);
  localparam logic [2:0] X_LAST = 3'(N - 1);

  feeder_state_t state_q, state_d;
  logic [5:0]  beat_q, beat_d;
  logic [2:0]  res_q, res_d;
  logic [3:0]  vec_q, vec_d;
  logic [3:0]  last_vec_q, last_vec_d;
  logic [7:0]  rd_addr_q, rd_addr_d;
  logic        inflight_q;
  logic        err_q, err_d;

  logic              sending_s, fifo_empty_s, valid_s, accept_s;
  logic              push_s, pop_s, rd_en_s, start_s, rx_s;
  logic [1:0]        fifo_count_s, occ_s;
  logic [DATA_W-1:0] fifo_data_s, head_s;

  assign sending_s    = (state_q == SEND_W) || (state_q == SEND_X);
  assign fifo_empty_s = (fifo_count_s == 2'd0);
  // Data arriving from the RAM this cycle counts as the FIFO head when the FIFO is empty.
  assign valid_s      = sending_s && (!fifo_empty_s || inflight_q);
  assign head_s       = fifo_empty_s ? src_data : fifo_data_s;
  assign accept_s     = valid_s && input_ready;
  assign push_s       = inflight_q && !(accept_s && fifo_empty_s);
  assign pop_s        = accept_s && !fifo_empty_s;
  assign occ_s        = fifo_count_s + {1'b0, inflight_q};
  assign rd_en_s      = sending_s && (occ_s < 2'd2) && (rd_addr_q < x_end_addr(vec_q));
  assign start_s      = cmd_start && (state_q == IDLE);
  assign rx_s         = output_valid && (state_q == RECV_Y);

  matmul_beat_fifo2 #(.W(DATA_W)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .data_i  (src_data),
    .data_o  (fifo_data_s),
    .count_o (fifo_count_s)
  );

  // State, counters, fetch address and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      beat_q     <= 6'd0;
      res_q      <= 3'd0;
      vec_q      <= 4'd0;
      last_vec_q <= 4'd0;
      rd_addr_q  <= 8'd0;
      inflight_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      res_q      <= res_d;
      vec_q      <= vec_d;
      last_vec_q <= last_vec_d;
      rd_addr_q  <= rd_addr_d;
      inflight_q <= rd_en_s;
      err_q      <= err_d;
    end
  end

  // Next-state and counter updates.
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    res_d      = res_q;
    vec_d      = vec_q;
    last_vec_d = last_vec_q;
    rd_addr_d  = rd_en_s ? (rd_addr_q + 8'd1) : rd_addr_q;
    case (state_q)
      IDLE: begin
        if (start_s) begin
          state_d    = cmd_load_w ? SEND_W : SEND_X;
          beat_d     = 6'd0;
          res_d      = 3'd0;
          vec_d      = 4'd0;
          last_vec_d = (cmd_nvec == 4'd0) ? 4'd0 : (cmd_nvec - 4'd1);
          rd_addr_d  = cmd_load_w ? 8'd0 : 8'(X_BASE);
        end else begin
          state_d = IDLE;
        end
      end
      SEND_W: begin
        if (accept_s && (beat_q == W_LAST)) begin
          beat_d  = 6'd0;
          state_d = SEND_X;
        end else if (accept_s) begin
          beat_d = beat_q + 6'd1;
        end else begin
          beat_d = beat_q;
        end
      end
      SEND_X: begin
        if (accept_s && (beat_q == {3'b000, X_LAST})) begin
          beat_d  = 6'd0;
          state_d = RECV_Y;
        end else if (accept_s) begin
          beat_d = beat_q + 6'd1;
        end else begin
          beat_d = beat_q;
        end
      end
      RECV_Y: begin
        if (rx_s && (res_q == X_LAST)) begin
          res_d = 3'd0;
          if (vec_q == last_vec_q) begin
            state_d = DONE;
          end else begin
            vec_d   = vec_q + 4'd1;
            state_d = SEND_X;
          end
        end else if (rx_s) begin
          res_d = res_q + 3'd1;
        end else begin
          res_d = res_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A stray result sets the error even on the cycle a new command is accepted.
  always_comb begin
    if (output_valid && (state_q != RECV_Y)) begin
      err_d = 1'b1;
    end else if (start_s) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  assign cmd_ready    = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign err          = err_q;
  assign src_rd_en    = rd_en_s;
  assign src_addr     = rd_addr_q;
  assign input_valid  = valid_s;
  assign data_to_mm   = valid_s ? head_s : '0;
  assign new_matrix   = valid_s && (state_q == SEND_W);
  assign output_ready = (state_q == RECV_Y);
  assign dst_wr_en    = rx_s;
  assign dst_addr     = rx_s ? {vec_q[3:0], res_q} : 7'd0;
  assign dst_data     = rx_s ? result : '0;

endmodule

// File: tb/tb_matmul_stream_feeder.sv
// Self-checking bench: operand/result RAM and multiplier models plus a per-cycle
// scoreboard of expected beats and result writes derived from the command.
module tb_matmul_stream_feeder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_start = 1'b0, cmd_ready, cmd_load_w = 1'b0;
  logic [3:0]  cmd_nvec = 4'd0;
  logic        busy, done, err, src_rd_en;
  logic [7:0]  src_addr;
  logic [7:0]  src_data = 8'd0;
  logic [7:0]  data_to_mm;
  logic        input_valid, input_ready = 1'b0, new_matrix;
  logic        output_valid = 1'b0, output_ready;
  logic [18:0] result = 19'd0;
  logic        dst_wr_en;
  logic [6:0]  dst_addr;
  logic [18:0] dst_data;

  matmul_stream_feeder dut (
    .clk(clk), .rst_n(rst_n), .cmd_start(cmd_start), .cmd_ready(cmd_ready),
    .cmd_load_w(cmd_load_w), .cmd_nvec(cmd_nvec), .busy(busy), .done(done), .err(err),
    .src_rd_en(src_rd_en), .src_addr(src_addr), .src_data(src_data),
    .data_to_mm(data_to_mm), .input_valid(input_valid), .input_ready(input_ready),
    .new_matrix(new_matrix), .output_valid(output_valid), .output_ready(output_ready),
    .result(result), .dst_wr_en(dst_wr_en), .dst_addr(dst_addr), .dst_data(dst_data)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] d; logic nm; } beat_t;
  typedef struct { logic [6:0] a; logic [18:0] d; } wr_t;

  logic [7:0]  src_mem [256];
  logic [18:0] dst_mem [128];
  logic [7:0]  wref [64];
  beat_t       exp_beats [$];
  wr_t         exp_wr [$];

  logic [7:0]  mm_w [64];
  logic [7:0]  mm_x [8];
  int          mm_wc = 0, mm_xc = 0;
  logic [18:0] mm_res [$];

  int errors = 0, checks = 0;
  int cyc = 0, beats_seen = 0, nm_seen = 0, done_seen = 0, wr_seen = 0;
  int first_beat_cyc = 0, last_beat_cyc = 0, ref_cyc = 0;
  bit rnd_rdy = 1'b0, rnd_ov = 1'b0, stray = 1'b0, mon_en = 1'b1;
  bit wait_first = 1'b0, hold_p = 1'b0;
  logic [7:0] hold_d;
  logic       hold_nm;

  always @(posedge clk) if (src_rd_en) src_data <= src_mem[src_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_src_rd_en"}, src_rd_en, 0);
    chk({tag, "_src_addr"}, src_addr, 0);
    chk({tag, "_input_valid"}, input_valid, 0);
    chk({tag, "_data_to_mm"}, data_to_mm, 0);
    chk({tag, "_new_matrix"}, new_matrix, 0);
    chk({tag, "_output_ready"}, output_ready, 0);
    chk({tag, "_dst_wr_en"}, dst_wr_en, 0);
    chk({tag, "_dst_addr"}, dst_addr, 0);
    chk({tag, "_dst_data"}, dst_data, 0);
  endtask

  // Expected beat order and result writes for one command, from the operand RAM image.
  task automatic plan(input bit lw, input int nv);
    int n;
    int acc;
    n = (nv == 0) ? 1 : nv;
    if (lw) begin
      for (int a = 0; a < 64; a++) begin
        exp_beats.push_back(beat_t'{src_mem[a], 1'b1});
        wref[a] = src_mem[a];
      end
    end
    for (int v = 0; v < n; v++) begin
      for (int k = 0; k < 8; k++) exp_beats.push_back(beat_t'{src_mem[64 + 8*v + k], 1'b0});
      for (int j = 0; j < 8; j++) begin
        acc = 0;
        for (int k = 0; k < 8; k++) acc += int'(wref[8*j + k]) * int'(src_mem[64 + 8*v + k]);
        exp_wr.push_back(wr_t'{7'(8*v + j), 19'(acc)});
      end
    end
  endtask

  task automatic monitor_cycle();
    beat_t b;
    wr_t   w;
    int    acc;
    if (cmd_start && cmd_ready) begin wait_first = 1'b1; ref_cyc = cyc; end
    if (hold_p) begin
      chk("stall_valid", input_valid, 1);
      chk("stall_data", data_to_mm, hold_d);
      chk("stall_nm", new_matrix, hold_nm);
      hold_p = 1'b0;
    end
    if (wait_first && input_valid) begin
      chk("first_beat_latency", cyc - ref_cyc, 2);
      wait_first = 1'b0;
    end
    if (input_valid && input_ready) begin
      checks++;
      if (exp_beats.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat: got data %0d nm %0d, expected no beat", data_to_mm, new_matrix);
      end else begin
        b = exp_beats.pop_front();
        chk("beat_data", data_to_mm, b.d);
        chk("beat_nm", new_matrix, b.nm);
      end
      if (beats_seen == 0) first_beat_cyc = cyc;
      last_beat_cyc = cyc;
      beats_seen++;
      if (new_matrix) begin
        nm_seen++;
        mm_w[mm_wc] = data_to_mm;
        mm_wc = (mm_wc + 1) % 64;
      end else begin
        mm_x[mm_xc] = data_to_mm;
        mm_xc++;
        if (mm_xc == 8) begin
          for (int j = 0; j < 8; j++) begin
            acc = 0;
            for (int k = 0; k < 8; k++) acc += int'(mm_w[8*j + k]) * int'(mm_x[k]);
            mm_res.push_back(19'(acc));
          end
          mm_xc = 0;
        end
      end
    end else if (input_valid) begin
      hold_p  = 1'b1;
      hold_d  = data_to_mm;
      hold_nm = new_matrix;
    end
    if (output_valid && output_ready) begin
      chk("wr_strobe", dst_wr_en, 1);
      checks++;
      if (exp_wr.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr %0d data %0d, expected no write", dst_addr, dst_data);
      end else begin
        w = exp_wr.pop_front();
        chk("dst_addr", dst_addr, w.a);
        chk("dst_data", dst_data, w.d);
      end
      dst_mem[dst_addr] = dst_data;
      if (!stray && mm_res.size() > 0) void'(mm_res.pop_front());
      wr_seen++;
      if ((wr_seen % 8) == 0 && exp_beats.size() > 0) begin wait_first = 1'b1; ref_cyc = cyc; end
    end else begin
      chk("no_write", dst_wr_en, 0);
    end
    if (done) begin
      done_seen++;
      chk("done_after_last_write", exp_wr.size(), 0);
    end
  endtask

  // Multiplier-side handshake driver and per-cycle scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      input_ready  = rnd_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
      output_valid = 1'b0;
      result       = 19'd0;
      if (stray) begin
        output_valid = 1'b1;
        result       = 19'h12345;
      end else if (mm_res.size() > 0 && (!rnd_ov || $urandom_range(0, 1) == 1)) begin
        output_valid = 1'b1;
        result       = mm_res[0];
      end
      #1;
      if (mon_en) monitor_cycle();
    end
  end

  task automatic clear_dst();
    for (int i = 0; i < 128; i++) dst_mem[i] = 19'h7ffff;
  endtask

  task automatic wait_done(input string tag);
    int d0;
    int n;
    d0 = done_seen;
    n  = 0;
    while (done_seen == d0 && n < 4000) begin @(negedge clk); #2; n++; end
    checks++;
    if (done_seen == d0) begin
      errors++;
      $display("FAIL %s_timeout: got no done after %0d cycles, expected done", tag, n);
    end
    repeat (3) @(negedge clk);
    #2;
    chk({tag, "_done_once"}, done_seen - d0, 1);
    chk({tag, "_beats_left"}, exp_beats.size(), 0);
    chk({tag, "_writes_left"}, exp_wr.size(), 0);
    chk({tag, "_back_idle"}, cmd_ready, 1);
  endtask

  task automatic issue(input bit lw, input logic [3:0] nv);
    @(negedge clk);
    cmd_load_w = lw;
    cmd_nvec   = nv;
    cmd_start  = 1'b1;
    @(negedge clk);
    cmd_start  = 1'b0;
  endtask

  initial begin
    int n;
    for (int a = 0; a < 256; a++) src_mem[a] = (a < 64) ? 8'(a) : 8'd1;
    clear_dst();
    #12;
    check_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: load W = i, one vector of ones, ready always high.
    beats_seen = 0; nm_seen = 0;
    plan(1'b1, 1);
    issue(1'b1, 4'd1);
    wait_done("t1");
    chk("t1_beats", beats_seen, 72);
    chk("t1_nm_beats", nm_seen, 64);
    chk("t1_no_bubbles", last_beat_cyc - first_beat_cyc, 71);
    chk("t1_y0", dst_mem[0], 28);
    chk("t1_y3", dst_mem[3], 220);
    chk("t1_y7", dst_mem[7], 476);
    chk("t1_err", err, 0);

    // 2: reuse W, three vectors.
    for (int i = 0; i < 24; i++) src_mem[64 + i] = 8'(i + 2);
    clear_dst();
    beats_seen = 0; nm_seen = 0;
    plan(1'b0, 3);
    issue(1'b0, 4'd3);
    wait_done("t2");
    chk("t2_beats", beats_seen, 24);
    chk("t2_nm_beats", nm_seen, 0);
    chk("t2_v0_y0", dst_mem[0], 196);
    chk("t2_v1_y0", dst_mem[8], 420);
    chk("t2_v2_y7", dst_mem[23], 10276);

    // 3: as test 1 with random beat and result stalls.
    for (int i = 0; i < 8; i++) src_mem[64 + i] = 8'd1;
    clear_dst();
    beats_seen = 0; nm_seen = 0;
    rnd_rdy = 1'b1; rnd_ov = 1'b1;
    plan(1'b1, 1);
    issue(1'b1, 4'd1);
    wait_done("t3");
    rnd_rdy = 1'b0; rnd_ov = 1'b0;
    chk("t3_beats", beats_seen, 72);
    chk("t3_nm_beats", nm_seen, 64);
    chk("t3_y7", dst_mem[7], 476);

    // 4: asynchronous reset in the middle of the W phase, then restart.
    beats_seen = 0;
    plan(1'b1, 1);
    issue(1'b1, 4'd1);
    n = 0;
    while (beats_seen < 30 && n < 500) begin @(negedge clk); #2; n++; end
    chk("t4_reached_beat30", (beats_seen >= 30) ? 1 : 0, 1);
    @(negedge clk);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check_idle_outputs("t4_async_rst");
    exp_beats.delete(); exp_wr.delete(); mm_res.delete();
    mm_wc = 0; mm_xc = 0; hold_p = 1'b0; wait_first = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    clear_dst();
    plan(1'b1, 1);
    issue(1'b1, 4'd1);
    #2;
    chk("t4_restart_rd_en", src_rd_en, 1);
    chk("t4_restart_addr", src_addr, 0);
    wait_done("t4");
    chk("t4_y0", dst_mem[0], 28);

    // 5: stray result while idle.
    @(negedge clk); #3; stray = 1'b1;
    @(negedge clk); #3; stray = 1'b0;
    chk("t5_stray_ready", output_ready, 0);
    @(negedge clk); #2;
    chk("t5_err_set", err, 1);
    repeat (3) @(negedge clk);
    #2;
    chk("t5_err_sticky", err, 1);

    // 6: start held high through a two-vector command.
    plan(1'b0, 2);
    cmd_load_w = 1'b0;
    cmd_nvec   = 4'd2;
    n = 0;
    while (n < 2000) begin
      @(negedge clk);
      if (done) begin cmd_start = 1'b0; break; end
      if (n == 2) chk("t6_err_cleared", err, 0);
      cmd_start = 1'b1;
      n++;
    end
    cmd_start = 1'b0;
    wait_done("t6");
    chk("t6_no_restart", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
